// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic countdown controller:
// phase enumeration, lamp encodings, default durations and display width.
package traffic_pkg;

  localparam int COUNT_W = 5;

  localparam int DEF_CLK_HZ         = 50_000_000;
  localparam int DEF_MAIN_GREEN     = 25;
  localparam int DEF_MAIN_YELLOW    = 5;
  localparam int DEF_COUNTRY_GREEN  = 20;
  localparam int DEF_COUNTRY_YELLOW = 5;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [1:0] {
    S_MG = 2'd0,
    S_MY = 2'd1,
    S_CG = 2'd2,
    S_CY = 2'd3
  } state_t;

  // Lamp pattern for a phase, packed as {main, country}.
  function automatic logic [5:0] phase_lamps(input state_t s);
    case (s)
      S_MG:    phase_lamps = {LAMP_G, LAMP_R};
      S_MY:    phase_lamps = {LAMP_Y, LAMP_R};
      S_CG:    phase_lamps = {LAMP_R, LAMP_G};
      S_CY:    phase_lamps = {LAMP_R, LAMP_Y};
      default: phase_lamps = {LAMP_G, LAMP_R};
    endcase
  endfunction

endpackage

// File: rtl/second_tick_gen.sv
// One-second prescaler: produces a single-cycle tick on the last count of
// each second and a registered blink flag that is high for the first half.
module second_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic CLK,
  input  logic RET,
  input  logic EN,
  output logic o_tick,
  output logic o_c
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_HZ / 2);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_c;

  always_comb begin
    w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
  end

  assign o_tick = EN && (r_cnt == LAST);
  assign o_c    = r_c;

  // C is computed from the next count so it always matches the count it sits beside.
  always_ff @(posedge CLK or negedge RET) begin
    if (!RET) begin
      r_cnt <= '0;
      r_c   <= 1'b1;
    end else if (EN) begin
      r_cnt <= w_cnt_nxt;
      r_c   <= (w_cnt_nxt < HALF);
    end
  end

endmodule

// File: rtl/traffic_countdown_ctrl.sv
// Four-phase main/country traffic light sequencer with per-road 1 Hz countdowns.
// Optional macro COUNTRY_SENSOR_EN adds CarSense: main green repeats while no car waits.
module traffic_countdown_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int MAIN_GREEN     = DEF_MAIN_GREEN,
  parameter int MAIN_YELLOW    = DEF_MAIN_YELLOW,
  parameter int COUNTRY_GREEN  = DEF_COUNTRY_GREEN,
  parameter int COUNTRY_YELLOW = DEF_COUNTRY_YELLOW
) (
  input  logic               CLK,
  input  logic               RET,
  input  logic               EN,
`ifdef COUNTRY_SENSOR_EN
  input  logic               CarSense,
`endif
  output logic [2:0]         MainLight,
  output logic [2:0]         CountryLight,
  output logic [COUNT_W-1:0] MainCountdown,
  output logic [COUNT_W-1:0] CountryCountdown,
  output logic               C
);

  if (CLK_HZ < 2 || (CLK_HZ % 2) != 0) begin : g_bad_clk
    $error("CLK_HZ must be even and at least 2");
  end
  if (MAIN_GREEN < 1 || MAIN_YELLOW < 1 || COUNTRY_GREEN < 1 || COUNTRY_YELLOW < 1) begin : g_bad_dur
    $error("every duration must be at least 1 second");
  end
  if (MAIN_GREEN + MAIN_YELLOW > 30 || COUNTRY_GREEN + COUNTRY_YELLOW > 30) begin : g_bad_range
    $error("per-road green+yellow must fit the 30 s display range");
  end

  localparam logic [COUNT_W-1:0] MG_CNT  = COUNT_W'(MAIN_GREEN);
  localparam logic [COUNT_W-1:0] MY_CNT  = COUNT_W'(MAIN_YELLOW);
  localparam logic [COUNT_W-1:0] CG_CNT  = COUNT_W'(COUNTRY_GREEN);
  localparam logic [COUNT_W-1:0] CY_CNT  = COUNT_W'(COUNTRY_YELLOW);
  localparam logic [COUNT_W-1:0] M_TOTAL = COUNT_W'(MAIN_GREEN + MAIN_YELLOW);
  localparam logic [COUNT_W-1:0] C_TOTAL = COUNT_W'(COUNTRY_GREEN + COUNTRY_YELLOW);
  localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

  logic               w_tick;
  logic               w_c;
  logic               w_car;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [COUNT_W-1:0] r_main_cd;
  logic [COUNT_W-1:0] r_cty_cd;
  logic [COUNT_W-1:0] w_main_nxt;
  logic [COUNT_W-1:0] w_cty_nxt;
  logic [2:0]         r_main_lamp;
  logic [2:0]         r_cty_lamp;
  logic [5:0]         w_lamps_nxt;

`ifdef COUNTRY_SENSOR_EN
  assign w_car = CarSense;
`else
  assign w_car = 1'b1;
`endif

  second_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .CLK    (CLK),
    .RET    (RET),
    .EN     (EN),
    .o_tick (w_tick),
    .o_c    (w_c)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main_cd;
    w_cty_nxt   = r_cty_cd;
    if (w_tick) begin
      case (r_state)
        S_MG: begin
          if (r_main_cd == ONE && w_car) begin
            w_state_nxt = S_MY;
            w_main_nxt  = MY_CNT;
            w_cty_nxt   = r_cty_cd - ONE;
          end else if (r_main_cd == ONE) begin
            // No car waiting on the country road: restart main green.
            w_main_nxt = MG_CNT;
            w_cty_nxt  = M_TOTAL;
          end else begin
            w_main_nxt = r_main_cd - ONE;
            w_cty_nxt  = r_cty_cd - ONE;
          end
        end
        S_MY: begin
          if (r_main_cd == ONE) begin
            w_state_nxt = S_CG;
            w_main_nxt  = C_TOTAL;
            w_cty_nxt   = CG_CNT;
          end else begin
            w_main_nxt = r_main_cd - ONE;
            w_cty_nxt  = r_cty_cd - ONE;
          end
        end
        S_CG: begin
          if (r_cty_cd == ONE) begin
            w_state_nxt = S_CY;
            w_main_nxt  = r_main_cd - ONE;
            w_cty_nxt   = CY_CNT;
          end else begin
            w_main_nxt = r_main_cd - ONE;
            w_cty_nxt  = r_cty_cd - ONE;
          end
        end
        S_CY: begin
          if (r_cty_cd == ONE) begin
            w_state_nxt = S_MG;
            w_main_nxt  = MG_CNT;
            w_cty_nxt   = M_TOTAL;
          end else begin
            w_main_nxt = r_main_cd - ONE;
            w_cty_nxt  = r_cty_cd - ONE;
          end
        end
        default: begin
          w_state_nxt = S_MG;
          w_main_nxt  = MG_CNT;
          w_cty_nxt   = M_TOTAL;
        end
      endcase
    end
  end

  assign w_lamps_nxt = phase_lamps(w_state_nxt);

  always_ff @(posedge CLK or negedge RET) begin
    if (!RET) begin
      r_state     <= S_MG;
      r_main_cd   <= MG_CNT;
      r_cty_cd    <= M_TOTAL;
      r_main_lamp <= LAMP_G;
      r_cty_lamp  <= LAMP_R;
    end else begin
      r_state     <= w_state_nxt;
      r_main_cd   <= w_main_nxt;
      r_cty_cd    <= w_cty_nxt;
      r_main_lamp <= w_lamps_nxt[5:3];
      r_cty_lamp  <= w_lamps_nxt[2:0];
    end
  end

  assign MainLight        = r_main_lamp;
  assign CountryLight     = r_cty_lamp;
  assign MainCountdown    = r_main_cd;
  assign CountryCountdown = r_cty_cd;
  assign C                = w_c;

endmodule

// File: tb/tb_traffic_countdown_ctrl.sv
// Directed bench for traffic_countdown_ctrl at CLK_HZ=4 (four cycles per tick).
module tb_traffic_countdown_ctrl;

  logic       CLK = 1'b0;
  logic       RET = 1'b1;
  logic       EN  = 1'b0;
`ifdef COUNTRY_SENSOR_EN
  logic       CarSense = 1'b1;
`endif
  logic [2:0] MainLight;
  logic [2:0] CountryLight;
  logic [4:0] MainCountdown;
  logic [4:0] CountryCountdown;
  logic       C;

  int checks     = 0;
  int passed     = 0;
  int ticks_done = 0;

  always #5 CLK = ~CLK;

  traffic_countdown_ctrl #(
    .CLK_HZ (4)
  ) dut (
    .CLK              (CLK),
    .RET              (RET),
    .EN               (EN),
`ifdef COUNTRY_SENSOR_EN
    .CarSense         (CarSense),
`endif
    .MainLight        (MainLight),
    .CountryLight     (CountryLight),
    .MainCountdown    (MainCountdown),
    .CountryCountdown (CountryCountdown),
    .C                (C)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input int ml, input int cl, input int mc, input int cc);
    check({tag, "_mainlight"}, {29'd0, MainLight}, ml);
    check({tag, "_countrylight"}, {29'd0, CountryLight}, cl);
    check({tag, "_maincd"}, {27'd0, MainCountdown}, mc);
    check({tag, "_countrycd"}, {27'd0, CountryCountdown}, cc);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic to_tick(input int n);
    repeat ((n - ticks_done) * 4) step();
    ticks_done = n;
  endtask

  initial begin
    // Async reset asserted away from any clock edge.
    #3 RET = 1'b0;
    #10;
    check_all("reset", 1, 4, 25, 30);
    check("reset_c", {31'd0, C}, 1);
    #4;
    RET = 1'b1;
    EN  = 1'b1;
    #1;
    check_all("release", 1, 4, 25, 30);
    check("release_c", {31'd0, C}, 1);
    check("release_tick", {31'd0, dut.u_tick.o_tick}, 0);

    // Blink flag and tick width over two seconds.
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("c_ph%0d", i), {31'd0, C}, ((i % 4) < 2) ? 1 : 0);
      check($sformatf("tick_ph%0d", i), {31'd0, dut.u_tick.o_tick}, ((i % 4) == 3) ? 1 : 0);
      if (i == 4) check_all("t1", 1, 4, 24, 29);
    end
    ticks_done = 2;
    check_all("t2", 1, 4, 23, 28);

    to_tick(24); check_all("t24", 1, 4, 1, 6);
    to_tick(25); check_all("t25_my", 2, 4, 5, 5);
    to_tick(29); check_all("t29", 2, 4, 1, 1);
    to_tick(30); check_all("t30_cg", 4, 1, 25, 20);
    to_tick(38); check_all("t38", 4, 1, 17, 12);

    // Pause on the cycle where a tick would fire.
    repeat (3) step();
    check("pre_pause_tick", {31'd0, dut.u_tick.o_tick}, 1);
    EN = 1'b0;
    #1;
    check("pause_tick", {31'd0, dut.u_tick.o_tick}, 0);
    repeat (10) step();
    check_all("pause_hold", 4, 1, 17, 12);
    check("pause_c", {31'd0, C}, 0);
    check("pause_tick2", {31'd0, dut.u_tick.o_tick}, 0);
    EN = 1'b1;
    step();
    check_all("resume", 4, 1, 16, 11);
    check("resume_c", {31'd0, C}, 1);
    ticks_done = 39;

    to_tick(49); check_all("t49", 4, 1, 6, 1);
    to_tick(50); check_all("t50_cy", 4, 2, 5, 5);
    to_tick(54); check_all("t54", 4, 2, 1, 1);
    to_tick(55); check_all("t55_mg", 1, 4, 25, 30);
    to_tick(107); check_all("t107_cy", 4, 2, 3, 3);

    // Reset mid-CY between clock edges, half way through a second.
    repeat (2) step();
    check("mid_c", {31'd0, C}, 0);
    #2 RET = 1'b0;
    #1;
    check_all("async_rst", 1, 4, 25, 30);
    check("async_rst_c", {31'd0, C}, 1);
    #3 RET = 1'b1;
    ticks_done = 0;

`ifdef COUNTRY_SENSOR_EN
    CarSense = 1'b0;
    to_tick(24); check_all("sense_t24", 1, 4, 1, 6);
    to_tick(25); check_all("sense_repeat", 1, 4, 25, 30);
    CarSense = 1'b1;
    to_tick(49); check_all("sense_t49", 1, 4, 1, 6);
    to_tick(50); check_all("sense_my", 2, 4, 5, 5);
`else
    to_tick(1); check_all("post_rst_t1", 1, 4, 24, 29);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
